exec_datapath: RTL and testbench
================================

Name: exec_datapath

Overview:
- Execute-stage block of the 9-bit-instruction, 8-bit-data accumulator-style processor.
- Merges three functions:
  - instruction decode (control signals);
  - 8-bit ALU;
  - 256x8 data memory.
- Sits between the register file, which supplies the A, B and loop-index (C) operands, and the register write-back path, which consumes wb_data.
- Program-counter logic lives outside; this block only produces branch_taken.

Parameters:
- DW, 8, data width of operands, result and memory words
- AW, 8, data memory address width (depth 2**AW = 256)
- IW, 9, instruction width

Ports:
- clk  input  1  single system clock; all writes occur on its rising edge
- reset  input  1  asynchronous, active-low reset
- instr  input  IW  machine code; opcode = instr[8:6], imm = instr[3:0], shift dir = instr[3]
- dat_a  input  DW  register operand A
- dat_b  input  DW  register operand B; store data; ADDI addend
- dat_c  input  DW  loop-index register value
- reg_dst  output  1  1 = write-back targets the loop register (instr[1:0]), 0 = instr[5:4]
- branch  output  1  instruction is a loop branch
- mem_write  output  1  data-memory write enable
- alu_src  output  1  1 = ALU A-operand is the zero-extended imm
- reg_write  output  1  register-file write enable
- mem_to_reg  output  1  write-back selects memory read data
- alu_op  output  3  equals instr[8:6]
- rslt  output  DW  ALU result; also the memory address
- wb_data  output  DW  equals mem_to_reg ? mem[rslt] : rslt
- zero  output  1  1 when rslt == 0
- branch_taken  output  1  branch && (dat_c != 0)

Behaviour:
- Decode and ALU are fully combinational: zero latency from instr and operands to every output.
- Opcode table (control bits: reg_dst, branch, mem_write, alu_src, reg_write, mem_to_reg; rslt):
  - 000 AND: 000010; rslt = A & B
  - 001 XOR: 000010; rslt = A ^ B
  - 010 ADD: 000010; rslt = (A + B) mod 256, carry discarded
  - 011 SHIFT: 000010; instr[3] = 0 → rslt = A << 1, instr[3] = 1 → rslt = A >> 1 (logical, zero fill)
  - 100 LW: 000011; rslt = A; wb_data = mem[A]
  - 101 SW: 001000; rslt = A; mem[A] <= B on the next rising clk edge
  - 110 LOOP: 110010; rslt = (C - 1) mod 256 (0 wraps to 0xFF); branch_taken = (C != 0)
  - 111 ADDI: 000110; rslt = ({4'b0, imm} + B) mod 256
- Memory:
  - 256 x 8; read is combinational and always available.
  - Write is synchronous on the posedge with mem_write = 1.
  - A read of the address being written returns the old value until the edge.
- Reset (reset = 0, asynchronous):
  - All memory words clear to 0x00 immediately.
  - mem_write, reg_write and branch_taken are forced to 0 while reset is low; other outputs stay combinational.
  - No write occurs on any edge while reset is low.
  - Deassertion takes effect at the next posedge.
- Reset asserted mid-cycle aborts a pending SW; no partial write.
- Back-to-back SW then LW to the same address: the LW sees the stored value in the following cycle.
- Unknown or X instr: outputs are don't-care; no memory write may occur when mem_write is not 1.

Test Plan:
- Reset low then high → every mem[i] = 0; instr = 100000000 with dat_a = 0x05 gives wb_data = 0x00, mem_to_reg = 1, reg_write = 1.
- AND 000000001, dat_a = 0xF0, dat_b = 0x3C → rslt = 0x30, reg_write = 1, alu_src = 0, zero = 0.
  - Then ADD 010000001 with 0xFF + 0x01 → rslt = 0x00, zero = 1.
- SW 101011000, dat_a = 0x10, dat_b = 0xA5, one clock → mem[0x10] = 0xA5, reg_write = 0.
  - Then LW 100100001 with dat_a = 0x10 → wb_data = 0xA5.
- ADDI 111100100 (imm = 4), dat_b = 0x0E → alu_src = 1, rslt = 0x12.
  - SHIFT 011001000, dat_a = 0x81 → rslt = 0x40.
- LOOP 110010100:
  - dat_c = 3 → branch = 1, reg_dst = 1, rslt = 0x02, branch_taken = 1.
  - dat_c = 0 → rslt = 0xFF, branch_taken = 0.
- SW pending with reset pulsed low before the edge → memory location stays 0x00 and all memory reads back 0.

Source files
------------

// File: rtl/exec_datapath.sv
// Execute stage of the 9-bit-instruction accumulator processor: decode, 8-bit ALU
// and a 256x8 data memory with combinational read and synchronous write.
module exec_datapath #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  input  logic [DW-1:0] dat_a,
  input  logic [DW-1:0] dat_b,
  input  logic [DW-1:0] dat_c,
  output logic          reg_dst,
  output logic          branch,
  output logic          mem_write,
  output logic          alu_src,
  output logic          reg_write,
  output logic          mem_to_reg,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] rslt,
  output logic [DW-1:0] wb_data,
  output logic          zero,
  output logic          branch_taken
);

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_LOOP  = 3'b110;
  localparam logic [2:0] OP_ADDI  = 3'b111;

  localparam int DEPTH = 2 ** AW;

  logic [2:0]    opcode;
  logic [3:0]    imm;
  logic          shift_right;
  logic          dec_reg_dst;
  logic          dec_branch;
  logic          dec_mem_write;
  logic          dec_alu_src;
  logic          dec_reg_write;
  logic          dec_mem_to_reg;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_rslt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd;
  logic          rst_act;
  logic [DW-1:0] mem [DEPTH];
  logic          unused_bits;

  assign opcode      = instr[8:6];
  assign imm         = instr[3:0];
  assign shift_right = instr[3];
  assign unused_bits = ^{instr[5:4], instr[2:0]};

  // Held high from the async assertion until the first posedge seen with reset
  // released, so a pulse that ends mid-cycle still blocks that cycle's write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_act <= 1'b1;
    else        rst_act <= 1'b0;
  end

  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    case (opcode)
      OP_AND, OP_XOR, OP_ADD, OP_SHIFT: begin
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
      end
      OP_LOOP: begin
        dec_reg_dst   = 1'b1;
        dec_branch    = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: begin
        dec_reg_write = 1'b0;
      end
    endcase
  end

  assign alu_a = dec_alu_src ? {{(DW-4){1'b0}}, imm} : dat_a;

  always_comb begin
    alu_rslt = '0;
    case (opcode)
      OP_AND:   alu_rslt = alu_a & dat_b;
      OP_XOR:   alu_rslt = alu_a ^ dat_b;
      OP_ADD:   alu_rslt = alu_a + dat_b;
      OP_SHIFT: alu_rslt = shift_right ? (alu_a >> 1) : (alu_a << 1);
      OP_LW:    alu_rslt = alu_a;
      OP_SW:    alu_rslt = alu_a;
      OP_LOOP:  alu_rslt = dat_c - DW'(1);
      OP_ADDI:  alu_rslt = alu_a + dat_b;
      default:  alu_rslt = '0;
    endcase
  end

  assign reg_dst      = dec_reg_dst;
  assign branch       = dec_branch;
  assign alu_src      = dec_alu_src;
  assign mem_to_reg   = dec_mem_to_reg;
  assign alu_op       = opcode;
  assign rslt         = alu_rslt;
  assign zero         = (alu_rslt == '0);
  assign mem_write    = dec_mem_write & ~rst_act;
  assign reg_write    = dec_reg_write & ~rst_act;
  assign branch_taken = dec_branch & (dat_c != '0) & ~rst_act;

  assign mem_addr = AW'(alu_rslt);
  assign mem_rd   = mem[mem_addr];
  assign wb_data  = dec_mem_to_reg ? mem_rd : alu_rslt;

  // Flop-based storage so the whole array clears the instant reset drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write == 1'b1) begin
      mem[mem_addr] <= dat_b;
    end
  end

endmodule

// File: tb/tb_exec_datapath.sv
// Directed-vector bench for exec_datapath; stimulus pushes expected outputs into a
// scoreboard queue and an independent monitor compares them on the falling edge.
module tb_exec_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] instr = '0;
  logic [7:0] dat_a = '0;
  logic [7:0] dat_b = '0;
  logic [7:0] dat_c = '0;
  logic       reg_dst, branch, mem_write, alu_src, reg_write, mem_to_reg;
  logic [2:0] alu_op;
  logic [7:0] rslt, wb_data;
  logic       zero, branch_taken;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [26:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  exec_datapath #(.DW(8), .AW(8), .IW(9)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .dat_a(dat_a), .dat_b(dat_b), .dat_c(dat_c),
    .reg_dst(reg_dst), .branch(branch), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .rslt(rslt), .wb_data(wb_data),
    .zero(zero), .branch_taken(branch_taken)
  );

  // ctrl = {reg_dst, branch, mem_write, alu_src, reg_write, mem_to_reg}
  task automatic vec(input string name, input logic [8:0] ins,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [5:0] ctrl, input logic [7:0] r,
                     input logic [7:0] wb, input logic bt);
    exp_t e;
    @(posedge clk);
    #1;
    instr = ins;
    dat_a = a;
    dat_b = b;
    dat_c = c;
    e.name = name;
    e.val  = {ctrl, ins[8:6], r, wb, (r == 8'h00), bt};
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [26:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        got = {reg_dst, branch, mem_write, alu_src, reg_write, mem_to_reg,
               alu_op, rslt, wb_data, zero, branch_taken};
        total++;
        if (got !== e.val) begin
          bad++;
          $display("FAIL %s: got=%h expected=%h", e.name, got, e.val);
        end
      end
    end
  end

  initial begin : stimulus
    // During reset: reg_write forced low, memory reads zero.
    vec("lw_in_reset", 9'b100000000, 8'h05, 8'h00, 8'h00, 6'b000001, 8'h05, 8'h00, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    vec("lw_after_reset", 9'b100000000, 8'h05, 8'h00, 8'h00, 6'b000011, 8'h05, 8'h00, 1'b0);
    vec("and",        9'b000000001, 8'hF0, 8'h3C, 8'h00, 6'b000010, 8'h30, 8'h30, 1'b0);
    vec("add_wrap",   9'b010000001, 8'hFF, 8'h01, 8'h00, 6'b000010, 8'h00, 8'h00, 1'b0);
    vec("xor",        9'b001000000, 8'h0F, 8'hFF, 8'h00, 6'b000010, 8'hF0, 8'hF0, 1'b0);
    vec("sw_10",      9'b101011000, 8'h10, 8'hA5, 8'h00, 6'b001000, 8'h10, 8'h10, 1'b0);
    vec("lw_10",      9'b100100001, 8'h10, 8'h00, 8'h00, 6'b000011, 8'h10, 8'hA5, 1'b0);
    vec("lw_11",      9'b100100001, 8'h11, 8'h00, 8'h00, 6'b000011, 8'h11, 8'h00, 1'b0);
    vec("addi_4",     9'b111100100, 8'h00, 8'h0E, 8'h00, 6'b000110, 8'h12, 8'h12, 1'b0);
    vec("addi_wrap",  9'b111101111, 8'h33, 8'hF5, 8'h00, 6'b000110, 8'h04, 8'h04, 1'b0);
    vec("shift_r",    9'b011001000, 8'h81, 8'h00, 8'h00, 6'b000010, 8'h40, 8'h40, 1'b0);
    vec("shift_l",    9'b011000000, 8'h81, 8'h00, 8'h00, 6'b000010, 8'h02, 8'h02, 1'b0);
    vec("loop_c3",    9'b110010100, 8'h00, 8'h00, 8'h03, 6'b110010, 8'h02, 8'h02, 1'b1);
    vec("loop_c0",    9'b110010100, 8'h00, 8'h00, 8'h00, 6'b110010, 8'hFF, 8'hFF, 1'b0);
    vec("loop_c1",    9'b110010100, 8'h00, 8'h00, 8'h01, 6'b110010, 8'h00, 8'h00, 1'b1);
    vec("sw_20",      9'b101011000, 8'h20, 8'h77, 8'h00, 6'b001000, 8'h20, 8'h20, 1'b0);
    vec("sw_30",      9'b101011000, 8'h30, 8'h5A, 8'h00, 6'b001000, 8'h30, 8'h30, 1'b0);
    vec("lw_20",      9'b100100001, 8'h20, 8'h00, 8'h00, 6'b000011, 8'h20, 8'h77, 1'b0);
    vec("lw_30",      9'b100100001, 8'h30, 8'h00, 8'h00, 6'b000011, 8'h30, 8'h5A, 1'b0);
    vec("lw_10_again", 9'b100100001, 8'h10, 8'h00, 8'h00, 6'b000011, 8'h10, 8'hA5, 1'b0);

    // Pending SW with a reset pulse that ends before the edge: write must abort.
    vec("sw_40_in_reset", 9'b101011000, 8'h40, 8'h99, 8'h00, 6'b000000, 8'h40, 8'h40, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    vec("lw_40_aborted", 9'b100100001, 8'h40, 8'h00, 8'h00, 6'b000011, 8'h40, 8'h00, 1'b0);
    vec("lw_20_cleared", 9'b100100001, 8'h20, 8'h00, 8'h00, 6'b000011, 8'h20, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      vec("scan_zero", 9'b100000000, 8'(i), 8'h00, 8'h00, 6'b000011, 8'(i), 8'h00, 1'b0);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
